// File: rtl/adsr_env_gen.sv
// ADSR envelope generator for one synth voice.
// Linear envelope with per-phase rate indices (period doubles per index step),
// optional HOLD after ATTACK, legato retrigger, phase code and end-of-cycle pulse.
// Gate events (vin edges as seen by the current phase) always win over phase
// completion and step ticks; in such a cycle the level does not step.
module adsr_env_gen #(
   parameter int nbit_data = 8,
   parameter int nbit_idx  = 4,
   parameter int nbit_cnt  = 28,
   parameter int step_base = 190,
   parameter int max_idx   = 14
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 vin,
   input  logic                 legato,
   input  logic                 hold_en,
   input  logic [nbit_idx-1:0]  a_t_idx,
   input  logic [nbit_idx-1:0]  h_t_idx,
   input  logic [nbit_idx-1:0]  d_t_idx,
   input  logic [nbit_data-1:0] s_level,
   input  logic [nbit_idx-1:0]  r_t_idx,
   output logic [nbit_data-1:0] dout,
   output logic                 vout,
   output logic [2:0]           phase,
   output logic                 eoc
);

   typedef enum logic [2:0] {
      PH_IDLE    = 3'd0,
      PH_ATTACK  = 3'd1,
      PH_HOLD    = 3'd2,
      PH_DECAY   = 3'd3,
      PH_SUSTAIN = 3'd4,
      PH_RELEASE = 3'd5
   } phase_t;

   localparam logic [nbit_data-1:0] cmax        = '1;
   localparam logic [nbit_cnt-1:0]  base_period = nbit_cnt'(step_base + 1);
   localparam logic [nbit_cnt-1:0]  cnt_one     = nbit_cnt'(1);

   phase_t               phase_q, phase_d;
   logic [nbit_data-1:0] dout_q, dout_d;
   logic [nbit_cnt-1:0]  cnt_q, cnt_d;
   logic                 eoc_q, eoc_d;

   logic [nbit_idx-1:0]  cur_idx;
   logic [nbit_cnt-1:0]  period_m1;
   logic                 count_en;
   logic                 tick;

   // Select the rate index of the active phase and derive its step period (clamped).
   always_comb begin
      cur_idx  = '0;
      count_en = 1'b0;
      case (phase_q)
         PH_ATTACK:  begin cur_idx = a_t_idx; count_en = 1'b1; end
         PH_HOLD:    begin cur_idx = h_t_idx; count_en = 1'b1; end
         PH_DECAY:   begin cur_idx = d_t_idx; count_en = 1'b1; end
         PH_RELEASE: begin cur_idx = r_t_idx; count_en = 1'b1; end
         default:    begin cur_idx = '0;      count_en = 1'b0; end
      endcase
      if (32'(cur_idx) > 32'(max_idx)) begin
         period_m1 = (base_period << max_idx) - cnt_one;
      end else begin
         period_m1 = (base_period << cur_idx) - cnt_one;
      end
      tick = count_en && (cnt_q == period_m1);
   end

   // Next phase, level, counter and end-of-cycle pulse.
   always_comb begin
      phase_d = phase_q;
      dout_d  = dout_q;
      eoc_d   = 1'b0;
      case (phase_q)
         PH_IDLE: begin
            if (vin) phase_d = PH_ATTACK;
         end
         PH_ATTACK: begin
            if (!vin)                phase_d = PH_RELEASE;
            else if (dout_q == cmax) phase_d = hold_en ? PH_HOLD : PH_DECAY;
            else if (tick)           dout_d  = dout_q + 1'b1;
         end
         PH_HOLD: begin
            if (!vin)      phase_d = PH_RELEASE;
            else if (tick) phase_d = PH_DECAY;
         end
         PH_DECAY: begin
            if (!vin)                    phase_d = PH_RELEASE;
            else if (dout_q <= s_level)  phase_d = PH_SUSTAIN;
            else if (tick)               dout_d  = dout_q - 1'b1;
         end
         PH_SUSTAIN: begin
            if (!vin) phase_d = PH_RELEASE;
         end
         PH_RELEASE: begin
            if (vin) begin
               phase_d = PH_ATTACK;
               if (!legato) dout_d = '0;
            end else if (dout_q == '0) begin
               phase_d = PH_IDLE;
               eoc_d   = 1'b1;
            end else if (tick) begin
               dout_d = dout_q - 1'b1;
            end
         end
         default: begin
            phase_d = PH_IDLE;
            dout_d  = '0;
         end
      endcase

      // Counter runs only in timed phases and restarts on every phase change.
      if (!count_en || (phase_d != phase_q) || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + cnt_one;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         phase_q <= PH_IDLE;
         dout_q  <= '0;
         cnt_q   <= '0;
         eoc_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         eoc_q   <= eoc_d;
      end
   end

   assign dout  = dout_q;
   assign phase = phase_q;
   assign vout  = (phase_q != PH_IDLE);
   assign eoc   = eoc_q;

endmodule

// File: tb/tb_adsr_env_gen.sv
// Bench for adsr_env_gen: fixed vector table for the planned scenarios,
// then randomized gate/level activity checked against a cycle model.
module tb_adsr_env_gen;

   localparam int NB   = 4;
   localparam int NI   = 5;
   localparam int SB   = 3;
   localparam int MI   = 14;
   localparam int NC   = 28;
   localparam int CMAX = (1 << NB) - 1;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          vin = 1'b0;
   logic          legato = 1'b0;
   logic          hold_en = 1'b0;
   logic [NI-1:0] a_t_idx = '0;
   logic [NI-1:0] h_t_idx = '0;
   logic [NI-1:0] d_t_idx = '0;
   logic [NI-1:0] r_t_idx = '0;
   logic [NB-1:0] s_level = '0;
   logic [NB-1:0] dout;
   logic          vout;
   logic [2:0]    phase;
   logic          eoc;

   // Clock generation.
   always #5 clk = ~clk;

   adsr_env_gen #(
      .nbit_data(NB), .nbit_idx(NI), .nbit_cnt(NC), .step_base(SB), .max_idx(MI)
   ) dut (
      .clk(clk), .rstn(rstn), .vin(vin), .legato(legato), .hold_en(hold_en),
      .a_t_idx(a_t_idx), .h_t_idx(h_t_idx), .d_t_idx(d_t_idx),
      .s_level(s_level), .r_t_idx(r_t_idx),
      .dout(dout), .vout(vout), .phase(phase), .eoc(eoc)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase numbers follow the published phase codes; the level and the time
   // spent in the current step are plain integers.
   int m_phase = 0;
   int m_level = 0;
   int m_elapsed = 0;
   int m_eoc = 0;

   function automatic int period(input int idx);
      int e;
      e = (idx > MI) ? MI : idx;
      return (SB + 1) * (1 << e);
   endfunction

   function automatic int idx_for(input int ph);
      case (ph)
         1: return int'(a_t_idx);
         2: return int'(h_t_idx);
         3: return int'(d_t_idx);
         5: return int'(r_t_idx);
         default: return 0;
      endcase
   endfunction

   task automatic model_edge();
      int  nxt;
      int  lvl;
      bit  timed;
      bit  step_due;
      if (!rstn) begin
         m_phase = 0; m_level = 0; m_elapsed = 0; m_eoc = 0;
         return;
      end
      m_eoc    = 0;
      nxt      = m_phase;
      lvl      = m_level;
      timed    = (m_phase == 1) || (m_phase == 2) || (m_phase == 3) || (m_phase == 5);
      step_due = timed && (m_elapsed + 1 == period(idx_for(m_phase)));
      case (m_phase)
         0: if (vin) nxt = 1;
         1: begin
            if (!vin) nxt = 5;
            else if (lvl == CMAX) nxt = hold_en ? 2 : 3;
            else if (step_due) lvl = lvl + 1;
         end
         2: begin
            if (!vin) nxt = 5;
            else if (step_due) nxt = 3;
         end
         3: begin
            if (!vin) nxt = 5;
            else if (lvl <= int'(s_level)) nxt = 4;
            else if (step_due) lvl = lvl - 1;
         end
         4: if (!vin) nxt = 5;
         5: begin
            if (vin) begin
               nxt = 1;
               if (!legato) lvl = 0;
            end else if (lvl == 0) begin
               nxt = 0; m_eoc = 1;
            end else if (step_due) lvl = lvl - 1;
         end
         default: begin nxt = 0; lvl = 0; end
      endcase
      if (nxt != m_phase || !timed || step_due) m_elapsed = 0;
      else m_elapsed = m_elapsed + 1;
      m_phase = nxt;
      m_level = lvl;
   endtask

   // One clock: advance the model with the inputs in force, then let the edge pass.
   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit rstn, vin, legato, hold_en;
      int a, h, d, r, s, n;
      int ph, dv;
      bit vo, eo;
   } vec_t;

   vec_t vecs[$];
   bit   c_he;
   int   c_a, c_h, c_d, c_r, c_s;

   function automatic void cfg(input bit he, input int a, input int h, input int d,
                               input int r, input int s);
      c_he = he; c_a = a; c_h = h; c_d = d; c_r = r; c_s = s;
   endfunction

   function automatic void add(input bit rn, input bit vi, input bit lg, input int n,
                               input int ph, input int dv, input bit vo, input bit eo);
      vec_t v;
      v.rstn = rn; v.vin = vi; v.legato = lg; v.hold_en = c_he;
      v.a = c_a; v.h = c_h; v.d = c_d; v.r = c_r; v.s = c_s; v.n = n;
      v.ph = ph; v.dv = dv; v.vo = vo; v.eo = eo;
      vecs.push_back(v);
   endfunction

   initial begin
      // Reset with gate already high, then release.
      cfg(0, 0, 0, 0, 0, 8);
      add(0, 1, 0, 2, 0, 0, 0, 0);
      add(1, 1, 0, 1, 1, 0, 1, 0);
      // Full envelope, all rates at index 0 (4 cycles per step), sustain 8.
      add(1, 1, 0, 3, 1, 0, 1, 0);
      add(1, 1, 0, 1, 1, 1, 1, 0);
      add(1, 1, 0, 55, 1, 14, 1, 0);
      add(1, 1, 0, 1, 1, 15, 1, 0);
      add(1, 1, 0, 1, 3, 15, 1, 0);
      add(1, 1, 0, 27, 3, 9, 1, 0);
      add(1, 1, 0, 1, 3, 8, 1, 0);
      add(1, 1, 0, 1, 4, 8, 1, 0);
      cfg(0, 0, 0, 0, 0, 2);            // sustain ignores a later s_level change
      add(1, 1, 0, 5, 4, 8, 1, 0);
      add(1, 0, 0, 1, 5, 8, 1, 0);
      add(1, 0, 0, 31, 5, 1, 1, 0);
      add(1, 0, 0, 1, 5, 0, 1, 0);
      add(1, 0, 0, 1, 0, 0, 0, 1);
      add(1, 0, 0, 1, 0, 0, 0, 0);
      // HOLD of 16 cycles at index 2.
      cfg(1, 0, 2, 0, 0, 8);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 1, 0, 61, 1, 15, 1, 0);
      add(1, 1, 0, 1, 2, 15, 1, 0);
      add(1, 1, 0, 15, 2, 15, 1, 0);
      add(1, 1, 0, 1, 3, 15, 1, 0);
      add(1, 1, 0, 4, 3, 14, 1, 0);
      // Attack index 20 clamps to 14: one step every 65536 cycles.
      cfg(0, 20, 0, 0, 0, 8);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 1, 0, 1, 1, 0, 1, 0);
      add(1, 1, 0, 65535, 1, 0, 1, 0);
      add(1, 1, 0, 1, 1, 1, 1, 0);
      // Retrigger, legato off then on.
      cfg(0, 0, 0, 0, 0, 4);
      for (int k = 0; k < 2; k++) begin
         add(0, 0, 0, 1, 0, 0, 0, 0);
         add(1, 1, 0, 62, 3, 15, 1, 0);
         add(1, 1, 0, 20, 3, 10, 1, 0);
         add(1, 0, 0, 1, 5, 10, 1, 0);
         add(1, 0, 0, 16, 5, 6, 1, 0);
         if (k == 0) begin
            add(1, 1, 0, 1, 1, 0, 1, 0);
         end else begin
            add(1, 1, 1, 1, 1, 6, 1, 0);
            add(1, 1, 1, 4, 1, 7, 1, 0);
         end
      end
      // Sustain at full scale: one-cycle DECAY.
      cfg(0, 0, 0, 0, 0, 15);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 1, 0, 62, 3, 15, 1, 0);
      add(1, 1, 0, 1, 4, 15, 1, 0);
      // Sustain at zero keeps the voice active.
      cfg(0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 1, 0, 62, 3, 15, 1, 0);
      add(1, 1, 0, 60, 3, 0, 1, 0);
      add(1, 1, 0, 1, 4, 0, 1, 0);
      add(1, 1, 0, 8, 4, 0, 1, 0);
      add(1, 0, 0, 1, 5, 0, 1, 0);
      add(1, 0, 0, 1, 0, 0, 0, 1);
      // Gate-off in ATTACK at level 3, off a tick.
      cfg(0, 0, 0, 0, 0, 8);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 1, 0, 1, 1, 0, 1, 0);
      add(1, 1, 0, 12, 1, 3, 1, 0);
      add(1, 0, 0, 1, 5, 3, 1, 0);
      add(1, 0, 0, 4, 5, 2, 1, 0);
      // Gate-off in the same cycle as an attack tick: no step.
      add(0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 1, 0, 1, 1, 0, 1, 0);
      add(1, 1, 0, 15, 1, 3, 1, 0);
      add(1, 0, 0, 1, 5, 3, 1, 0);
      add(1, 0, 0, 3, 5, 3, 1, 0);
      add(1, 0, 0, 1, 5, 2, 1, 0);
      // Reset in RELEASE at level 9: no eoc.
      cfg(0, 0, 0, 0, 0, 9);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 1, 0, 62, 3, 15, 1, 0);
      add(1, 1, 0, 24, 3, 9, 1, 0);
      add(1, 1, 0, 1, 4, 9, 1, 0);
      add(1, 0, 0, 1, 5, 9, 1, 0);
      add(1, 0, 0, 2, 5, 9, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 0, 0, 1, 0, 0, 0, 0);

      #2;
      foreach (vecs[i]) begin
         rstn    = vecs[i].rstn;
         vin     = vecs[i].vin;
         legato  = vecs[i].legato;
         hold_en = vecs[i].hold_en;
         a_t_idx = NI'(vecs[i].a);
         h_t_idx = NI'(vecs[i].h);
         d_t_idx = NI'(vecs[i].d);
         r_t_idx = NI'(vecs[i].r);
         s_level = NB'(vecs[i].s);
         repeat (vecs[i].n) cycle();
         chk($sformatf("vec%0d phase", i), int'(phase), vecs[i].ph);
         chk($sformatf("vec%0d dout", i),  int'(dout),  vecs[i].dv);
         chk($sformatf("vec%0d vout", i),  int'(vout),  int'(vecs[i].vo));
         chk($sformatf("vec%0d eoc", i),   int'(eoc),   int'(vecs[i].eo));
      end

      // Randomized activity against the model. Rate indices only change
      // together with a gate toggle, so no counter is ever left beyond its period.
      rstn = 1'b0;
      cycle();
      for (int c = 0; c < 4000; c++) begin
         rstn = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 79) == 0) begin
            vin     = ~vin;
            legato  = 1'($urandom_range(0, 1));
            hold_en = 1'($urandom_range(0, 1));
            a_t_idx = NI'($urandom_range(0, 2));
            h_t_idx = NI'($urandom_range(0, 2));
            d_t_idx = NI'($urandom_range(0, 2));
            r_t_idx = NI'($urandom_range(0, 2));
         end
         if ($urandom_range(0, 29) == 0) s_level = NB'($urandom_range(0, CMAX));
         cycle();
         chk($sformatf("rand%0d phase", c), int'(phase), m_phase);
         chk($sformatf("rand%0d dout", c),  int'(dout),  m_level);
         chk($sformatf("rand%0d vout", c),  int'(vout),  (m_phase != 0) ? 1 : 0);
         chk($sformatf("rand%0d eoc", c),   int'(eoc),   m_eoc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/adsr_env_gen.md
Name: adsr_env_gen

Overview:
- Parametrised successor of the single-voice ADSR envelope generator.
- Produces a linear envelope of configurable width.
- Phases: IDLE, ATTACK, optional HOLD, DECAY, SUSTAIN, RELEASE.
- Per-phase exponential-range rate indices, legato retrigger mode, phase code output and end-of-cycle pulse.
- Sits between the note gate logic and the amplitude multiplier of each synth voice.

Parameters:
- nbit_data, 8, envelope output width; peak level cmax = 2**nbit_data-1
- nbit_idx, 4, width of each rate index input
- nbit_cnt, 28, step counter width; must hold (step_base+1)*2**max_idx-1
- step_base, 190, base step period minus one, in clk cycles
- max_idx, 14, largest legal rate index; larger inputs clamp to max_idx

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- vin  in  1  note gate, 1 = key held
- legato  in  1  1 = retrigger from current level, 0 = retrigger from zero
- hold_en  in  1  1 = insert HOLD phase after ATTACK
- a_t_idx  in  nbit_idx  attack rate index
- h_t_idx  in  nbit_idx  hold duration index
- d_t_idx  in  nbit_idx  decay rate index
- s_level  in  nbit_data  sustain level
- r_t_idx  in  nbit_idx  release rate index
- dout  out  nbit_data  envelope value, registered
- vout  out  1  1 in any phase except IDLE
- phase  out  3  IDLE=0, ATTACK=1, HOLD=2, DECAY=3, SUSTAIN=4, RELEASE=5
- eoc  out  1  one-cycle pulse when RELEASE completes

Behaviour:
- Reset: sampled on clk rising edge while rstn=0, also mid-envelope. Result: phase=IDLE, dout=0, vout=0, eoc=0, step counter=0.
- Step period: P(i) = (step_base+1)*2**min(i,max_idx) cycles, using the index of the current phase.
- Step counter: counts 0..P-1 in ATTACK/HOLD/DECAY/RELEASE, wraps to 0. It is held at 0 in IDLE/SUSTAIN and cleared on every phase change. The tick is asserted combinationally when count == P-1.
- Index changes mid-phase take effect at once. If count already exceeds the new P-1, the counter keeps counting and wraps at nbit_cnt; this is not guarded.
- All phase and dout updates are registered and visible the cycle after the causing condition.
- IDLE:
  - vin=1 -> ATTACK.
- ATTACK:
  - Tick with dout<cmax -> dout+1.
  - dout==cmax -> HOLD if hold_en=1, else DECAY.
- HOLD:
  - dout stays at cmax.
  - Tick with h_t_idx period -> DECAY. Hold lasts exactly P(h_t_idx) cycles.
- DECAY:
  - Tick with dout>s_level -> dout-1.
  - dout<=s_level -> SUSTAIN.
  - If s_level>=cmax, DECAY lasts one cycle.
- SUSTAIN:
  - dout is held at its current value; later s_level changes are ignored.
- RELEASE:
  - Tick with dout>0 -> dout-1.
  - dout==0 -> IDLE, with eoc=1 for that one transition cycle.
- Gate-off: vin=0 in ATTACK/HOLD/DECAY/SUSTAIN -> RELEASE. dout is held and release starts from the current level.
- Gate-on: vin=1 in RELEASE -> ATTACK.
  - legato=0: dout set to 0 on the same edge.
  - legato=1: dout keeps its value.
- Priority: gate events win over phase completion and ticks in the same cycle. In that cycle dout does not step.
- Example: in RELEASE with dout==0 and vin=1, the next phase is ATTACK and eoc stays 0.
- vout = (phase != IDLE), derived from the phase register.
- Arithmetic: dout never wraps; it saturates at 0 and cmax.
- Unused phase codes 6/7 recover to IDLE on the next edge.

Test Plan:
All tests use nbit_data=4, step_base=3, so P(0)=4 and cmax=15.
1. Reset: rstn=0 for 2 cycles, vin=1 -> phase=0, dout=0, vout=0, eoc=0. After rstn=1, phase=1 on the next edge.
2. Full envelope: a=d=r=0, hold_en=0, s_level=8, vin=1.
   - dout increments every 4 cycles and reaches 15 after 60 cycles in ATTACK.
   - Then DECAY; dout reaches 8 after 28 cycles; then SUSTAIN.
   - vin=0 -> RELEASE; dout reaches 0 after 32 cycles.
   - Then IDLE with a single eoc pulse.
3. Hold and rate index: hold_en=1, h_t_idx=2 -> HOLD lasts 16 cycles at dout=15. With a_t_idx=20, the attack step period is clamped to 4*2**14.
4. Retrigger: vin drops at dout=10 in DECAY, then rises at dout=6 in RELEASE.
   - legato=0 -> ATTACK with dout=0.
   - legato=1 -> ATTACK continues from 6.
5. Boundaries:
   - s_level=15 -> DECAY lasts 1 cycle.
   - s_level=0 -> sustain at 0 with vout=1.
   - vin=0 during ATTACK at dout=3 -> RELEASE from 3.
   - Same-cycle tick and gate-off -> no dout step.
6. Mid-operation reset: assert rstn=0 during RELEASE at dout=9 -> all outputs return to reset values on the next edge; eoc is not pulsed.
